// File: rtl/im_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the program loader.
// master drives the byte stream and observes the memory port; slave is the loader.
interface im_loader_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;

  modport master (
    output byte_valid, byte_data, byte_last,
    input  byte_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    input  byte_valid, byte_data, byte_last,
    output byte_ready, im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Program loader: zero-fills the instruction memory, then packs an MSB-first
// byte stream into 32-bit words and writes them from address 0 upwards.
// busy holds the CPU until the image ends (done) or overflows the memory (error).
module im_loader #(
  parameter int IM_SIZE = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  im_loader_if.slave      bus,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IM_SIZE - 1);
  localparam logic [ADDR_W:0]   WC_LAST   = (ADDR_W + 1)'(IM_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t     state;
  logic [1:0] byte_idx;
  logic       last_word;

  // Drops byte b into lane k of word w; lane 0 is the most significant byte.
  function automatic logic [31:0] pack_byte(input logic [31:0] w,
                                            input logic [1:0]  k,
                                            input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  // Loader FSM; every output is a register so the memory port and handshake are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      byte_idx       <= '0;
      last_word      <= 1'b0;
      bus.byte_ready <= 1'b0;
      bus.im_we      <= 1'b0;
      bus.im_waddr   <= '0;
      bus.im_wdata   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      word_count     <= '0;
    end else begin
      case (state)
        // Start is only honoured while not busy; a byte offered alongside it is left pending.
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= CLEAR;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            word_count   <= '0;
            byte_idx     <= '0;
            bus.im_we    <= 1'b1;
            bus.im_waddr <= '0;
            bus.im_wdata <= '0;
          end
        end
        // One zero word per cycle over the whole memory; the packer leaves this state empty.
        CLEAR: begin
          if (bus.im_waddr == LAST_ADDR) begin
            state          <= RECV;
            bus.im_we      <= 1'b0;
            bus.byte_ready <= 1'b1;
          end else begin
            bus.im_waddr <= bus.im_waddr + 1'b1;
          end
        end
        // Pack accepted bytes; a fourth byte or a flagged last byte closes the word.
        RECV: begin
          if (bus.byte_valid && bus.byte_ready) begin
            bus.im_wdata <= pack_byte(bus.im_wdata, byte_idx, bus.byte_data);
            byte_idx     <= byte_idx + 2'd1;
            if (byte_idx == 2'd3 || bus.byte_last) begin
              state          <= WRITE;
              bus.byte_ready <= 1'b0;
              bus.im_we      <= 1'b1;
              bus.im_waddr   <= word_count[ADDR_W-1:0];
              last_word      <= bus.byte_last;
            end
          end
        end
        // Single write cycle; overflow is only an error when the image has not ended.
        WRITE: begin
          bus.im_we  <= 1'b0;
          word_count <= word_count + 1'b1;
          if (last_word) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (word_count == WC_LAST) begin
            state <= ERR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            state          <= RECV;
            bus.byte_ready <= 1'b1;
            bus.im_wdata   <= '0;
            byte_idx       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: the bench acts as the instruction memory, and every load
// is compared against a reference image built directly from the byte stream.
module tb_im_loader;
  localparam int IM_SIZE = 1024;
  localparam int ADDR_W  = 10;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            error;
  logic [ADDR_W:0] word_count;

  int n_chk = 0;
  int n_err = 0;

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.IM_SIZE(IM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Instruction memory model plus write accounting.
  logic [31:0] mem [IM_SIZE];
  int wr_cnt  = 0;
  int we_idle = 0;
  always @(posedge clk) begin
    if (bus.im_we) begin
      mem[bus.im_waddr] <= bus.im_wdata;
      wr_cnt <= wr_cnt + 1;
      if (!busy) we_idle <= we_idle + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offers each byte and holds it until the loader takes it; optional random gaps
  // carry stray start pulses, which must be ignored while the loader is busy.
  task automatic send_stream(input logic [7:0] q[$], input bit has_last,
                             input int gap_pct, input bit with_start);
    for (int i = 0; i < q.size(); i++) begin
      bit acc;
      int guard;
      if (i > 0) begin
        while ($urandom_range(99) < gap_pct) begin
          bus.byte_valid = 1'b0;
          start = ($urandom_range(3) == 0);
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = q[i];
      bus.byte_last  = has_last && (i == q.size() - 1);
      if (with_start && i == 0) start = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 3000) begin
        @(negedge clk);
        acc = bus.byte_ready;
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
      end
      if (!acc) begin
        check_eq("accept_timeout", 0, 1);
        bus.byte_valid = 1'b0;
        return;
      end
    end
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  // Reference: the memory is all zero except the first words, which are the
  // stream cut into 4-byte big-endian groups (short tail zero-padded), capped at IM_SIZE words.
  task automatic verify_load(input string tag, input logic [7:0] q[$],
                             input bit has_last, input int base);
    logic [31:0] exp_mem [IM_SIZE];
    int n_acc, n_words, mism, guard;
    bit exp_err;
    exp_err = !has_last;
    n_acc   = (q.size() > 4 * IM_SIZE) ? 4 * IM_SIZE : q.size();
    n_words = (n_acc + 3) / 4;
    foreach (exp_mem[a]) exp_mem[a] = 32'h0;
    for (int i = 0; i < n_acc; i++)
      exp_mem[i / 4] = exp_mem[i / 4] | (32'(q[i]) << (8 * (3 - (i % 4))));
    guard = 0;
    while (!(done || error) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq({tag, " done"},       done,          !exp_err);
    check_eq({tag, " error"},      error,         exp_err);
    check_eq({tag, " busy"},       busy,          0);
    check_eq({tag, " byte_ready"}, bus.byte_ready, 0);
    check_eq({tag, " word_count"}, word_count,    n_words);
    check_eq({tag, " writes"},     wr_cnt - base, IM_SIZE + n_words);
    mism = 0;
    foreach (mem[a]) if (mem[a] !== exp_mem[a]) mism++;
    check_eq({tag, " mem_mismatches"}, mism, 0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] q[$],
                          input bit has_last, input int gap_pct);
    int base;
    base = wr_cnt;
    send_stream(q, has_last, gap_pct, 1'b1);
    verify_load(tag, q, has_last, base);
  endtask

  initial begin
    logic [7:0] q[$];
    int base, rdy_seen;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst ctrl", {bus.byte_ready, bus.im_we, busy, done, error}, 0);
    check_eq("rst waddr", bus.im_waddr, 0);
    check_eq("rst wdata", bus.im_wdata, 0);
    check_eq("rst word_count", word_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Two full words
    q = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
    run_load("t1", q, 1'b1, 0);
    check_eq("t1 addr0", mem[0], 32'h24010005);
    check_eq("t1 addr1", mem[1], 32'h8C020004);

    // Short final word is zero-padded
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load("t2", q, 1'b1, 0);
    check_eq("t2 addr0", mem[0], 32'hAABBCCDD);
    check_eq("t2 addr1", mem[1], 32'hEE000000);

    // Overflow: a full memory without last ends in error; further bytes are refused
    q = {};
    for (int i = 0; i < 4 * IM_SIZE; i++) q.push_back(8'($urandom));
    run_load("t3", q, 1'b0, 0);
    base = wr_cnt;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    rdy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.byte_ready) rdy_seen++;
    end
    bus.byte_valid = 1'b0;
    check_eq("t3 ready_after_err", rdy_seen, 0);
    check_eq("t3 writes_after_err", wr_cnt - base, 0);

    // Random images with gaps and stray start pulses
    for (int n = 0; n < 6; n++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(40, 1)); i++) q.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", n), q, 1'b1, 40);
    end

    // The final word may land on the last address and still end in done
    q = {};
    for (int i = 0; i < 4 * IM_SIZE - 2; i++) q.push_back(8'($urandom));
    run_load("full", q, 1'b1, 0);

    // Reset asserted while a 4th byte is being offered
    q = '{8'h11, 8'h22, 8'h33};
    send_stream(q, 1'b0, 0, 1'b1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h44;
    bus.byte_last  = 1'b0;
    @(negedge clk);
    check_eq("rst4 ready_before", bus.byte_ready, 1);
    base = wr_cnt;
    reset = 1'b0;
    #1;
    check_eq("rst4 ctrl_async", {bus.byte_ready, bus.im_we, busy, done, error}, 0);
    check_eq("rst4 wdata_async", bus.im_wdata, 0);
    check_eq("rst4 word_count_async", word_count, 0);
    @(posedge clk); #1;
    check_eq("rst4 im_we", bus.im_we, 0);
    check_eq("rst4 no_write", wr_cnt - base, 0);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reload erases the previous larger image
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load("t6a", q, 1'b1, 0);
    q = '{8'h00, 8'h00, 8'h00, 8'h01};
    run_load("t6b", q, 1'b1, 20);
    check_eq("t6b addr0", mem[0], 32'h00000001);
    check_eq("t6b addr1", mem[1], 32'h00000000);

    check_eq("we_while_idle", we_idle, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
